vlc_lane_sched: RTL and testbench
=================================

VLC_LANE_SCHED -- requirements
Module: vlc_lane_sched

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 1023: watchdog limit in cycles, 10-bit, used only under VLC_SCHED_TIMEOUT_EN.
REQ-002 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-003 SHALL have port rstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  run start pulse.
REQ-005 SHALL have port encode_done  input  1  upstream encoder finished all symbols.
REQ-006 SHALL have port lane_empty  input  4  per-lane VLC FIFO empty, lane i at bit i.
REQ-007 SHALL have port lane_seg_done  input  4  lane i has written every code of its current segment.
REQ-008 SHALL have port lane_rd  output  4  FIFO read strobe, at most one bit set.
REQ-009 SHALL have port lane_code  input  64  lane i code at [16i+15:16i], left-aligned, valid the cycle after lane_rd.
REQ-010 SHALL have port lane_len  input  20  lane i length at [5i+4:5i], valid with lane_code.
REQ-011 SHALL have ports pk_valid output 1, pk_code output 16, pk_len output 5, and pk_ready input 1, forming the code handshake to the bit packer.
REQ-012 SHALL have ports pk_flush output 1 (flush pulse) and pk_flush_ack input 1.
REQ-013 SHALL have ports busy output 1, done output 1, cur_lane output 2, bit_cnt output 32 (bits issued in the run), and err_timeout output 1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, READ, HOLD, NEXT, FLUSH, DONE.
REQ-015 In IDLE or DONE, start SHALL go to WAIT with cur_lane=0 and bit_cnt=0; start in any other state SHALL be ignored.
REQ-016 WAIT priority SHALL be: (1) lane_empty[cur]&lane_seg_done[cur] -> NEXT; (2) !lane_empty[cur] -> assert lane_rd[cur] for exactly this one cycle and go to READ; (3) else stay.
REQ-017 READ SHALL register lane_code/lane_len of cur_lane; len 0 -> discard and return to WAIT; len>16 -> saturate to 16; else go to HOLD.
REQ-018 HOLD SHALL drive pk_valid=1 with pk_code/pk_len stable until pk_ready=1; on transfer, add pk_len to bit_cnt (32-bit wrap) and go to WAIT the next cycle.
REQ-019 Peak rate SHALL be one code per 3 cycles (WAIT, READ, HOLD with pk_ready=1).
REQ-020 NEXT SHALL advance cur_lane modulo 4 (3->0); if encode_done and all lane_empty -> FLUSH, else WAIT.
REQ-021 FLUSH SHALL pulse pk_flush for the entry cycle only, then wait for pk_flush_ack -> DONE; an ack in the pulse cycle SHALL be accepted.
REQ-022 DONE SHALL hold done=1 and keep bit_cnt until the next start.
REQ-023 busy SHALL be 1 in every state except IDLE and DONE.
REQ-024 lane_rd SHALL never assert when the addressed lane is empty, or outside WAIT.
REQ-025 Codes SHALL be issued in lane order 0,1,2,3,0,... per segment, with no reordering within a lane.

Reset
REQ-026 rstN low SHALL asynchronously force IDLE and all outputs to 0 (pk_code, pk_len, bit_cnt, cur_lane, err_timeout included).
REQ-027 Reset mid-operation SHALL abandon any read or held code without replay; the next start begins at lane 0.

Configuration
REQ-028 With VLC_SCHED_TIMEOUT_EN defined, a 10-bit counter SHALL count consecutive WAIT cycles where lane_empty[cur]&!lane_seg_done[cur]; it SHALL clear on leaving WAIT or on a read.
REQ-029 With VLC_SCHED_TIMEOUT_EN defined, reaching TO_CYCLES SHALL force NEXT and set sticky err_timeout, cleared only by start or reset.
REQ-030 Without VLC_SCHED_TIMEOUT_EN, there SHALL be no counter, err_timeout SHALL be tied 0, and WAIT SHALL wait indefinitely.

Verification
REQ-031 Lanes 0-3 each hold one code of len 5, all seg_done, encode_done=1, pk_ready=1 -> 4 transfers in lane order, bit_cnt=20, one pk_flush, done=1.
REQ-032 pk_ready held low for 10 cycles in HOLD -> pk_valid, pk_code and pk_len are stable for all 10 cycles, no lane_rd, exactly one transfer.
REQ-033 Lane 1 code len=0, lane 2 code len=20 -> lane 1 code is dropped; lane 2 code is issued with pk_len=16, bit_cnt+=16.
REQ-034 rstN asserted while in HOLD -> outputs 0 immediately; after start, the first lane_rd is on lane 0.
REQ-035 Timeout enabled, TO_CYCLES=8, lane 2 empty and not seg_done -> after 8 cycles cur_lane=3 and err_timeout=1; next start clears it.

Source files
------------

// File: rtl/vlc_lane_sched.sv
// vlc_lane_sched: round-robin scheduler draining four VLC lane FIFOs into the bit packer.
// Optional stalled-lane watchdog is enabled by defining VLC_SCHED_TIMEOUT_EN.
module vlc_lane_sched #(
    parameter int unsigned TO_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic        encode_done,
    input  logic [3:0]  lane_empty,
    input  logic [3:0]  lane_seg_done,
    output logic [3:0]  lane_rd,
    input  logic [63:0] lane_code,
    input  logic [19:0] lane_len,
    output logic        pk_valid,
    output logic [15:0] pk_code,
    output logic [4:0]  pk_len,
    input  logic        pk_ready,
    output logic        pk_flush,
    input  logic        pk_flush_ack,
    output logic        busy,
    output logic        done,
    output logic [1:0]  cur_lane,
    output logic [31:0] bit_cnt,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        HOLD,
        NEXT,
        FLUSH,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cur_q, cur_d;
    logic [15:0] code_q, code_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] bits_q, bits_d;
    logic        flush_q, flush_d;

    logic [15:0] codes [4];
    logic [4:0]  lens [4];
    logic        cur_empty;
    logic        cur_sdone;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            codes[i] = lane_code[16*i +: 16];
            lens[i]  = lane_len[5*i +: 5];
        end
    end

    assign cur_empty = lane_empty[cur_q];
    assign cur_sdone = lane_seg_done[cur_q];

`ifdef VLC_SCHED_TIMEOUT_EN
    localparam logic [9:0] TO_LIM = 10'(TO_CYCLES);

    logic [9:0] to_q, to_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic [9:0] unused_to;

    assign unused_to   = 10'(TO_CYCLES);
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cur_q   <= '0;
            code_q  <= '0;
            len_q   <= '0;
            bits_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            code_q  <= code_d;
            len_q   <= len_d;
            bits_q  <= bits_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        code_d  = code_q;
        len_d   = len_q;
        bits_d  = bits_q;
        flush_d = 1'b0;
        lane_rd = '0;
`ifdef VLC_SCHED_TIMEOUT_EN
        to_d    = '0;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT;
                    cur_d   = '0;
                    bits_d  = '0;
`ifdef VLC_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            WAIT: begin
                if (cur_empty && cur_sdone) begin
                    state_d = NEXT;
                end else if (!cur_empty) begin
                    lane_rd[cur_q] = 1'b1;
                    state_d        = READ;
`ifdef VLC_SCHED_TIMEOUT_EN
                end else if (to_q == TO_LIM - 10'd1) begin
                    // Lane starved too long: skip it and flag it.
                    state_d = NEXT;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + 10'd1;
`endif
                end
            end
            READ: begin
                if (lens[cur_q] == 5'd0) begin
                    state_d = WAIT;
                end else begin
                    code_d  = codes[cur_q];
                    len_d   = (lens[cur_q] > 5'd16) ? 5'd16 : lens[cur_q];
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (pk_ready) begin
                    bits_d  = bits_q + 32'(len_q);
                    state_d = WAIT;
                end
            end
            NEXT: begin
                cur_d = cur_q + 2'd1;
                if (encode_done && (&lane_empty)) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            FLUSH: begin
                if (pk_flush_ack) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pk_valid = (state_q == HOLD);
    assign pk_code  = code_q;
    assign pk_len   = len_q;
    assign pk_flush = flush_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign cur_lane = cur_q;
    assign bit_cnt  = bits_q;

endmodule

// File: tb/tb_vlc_lane_sched.sv
// tb_vlc_lane_sched: scoreboard bench with lane FIFO models and a rule-level
// reference of the expected code stream.
module tb_vlc_lane_sched;

    localparam int TO = 8;

    typedef struct packed {
        logic [15:0] code;
        logic [4:0]  len;
    } cw_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic        encode_done = 1'b0;
    logic [3:0]  lane_empty = 4'hf;
    logic [3:0]  lane_seg_done = 4'hf;
    logic [3:0]  lane_rd;
    logic [63:0] lane_code = '0;
    logic [19:0] lane_len = '0;
    logic        pk_valid;
    logic [15:0] pk_code;
    logic [4:0]  pk_len;
    logic        pk_ready = 1'b0;
    logic        pk_flush;
    logic        pk_flush_ack = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  cur_lane;
    logic [31:0] bit_cnt;
    logic        err_timeout;

    int n_chk = 0;
    int n_fail = 0;

    cw_t pend[4][$];
    int  pend_n[4][$];
    cw_t towr[4][$];
    cw_t fifo[4][$];
    cw_t exp_q[$];
    logic [31:0] exp_bits;
    int  flush_seen = 0;
    int  rdy_mode = 0;
    int  rd_req = -1;
    bit  want_first = 0;
    bit  freeze[4];
    int  cd[4];

    always #5 clk = ~clk;

    vlc_lane_sched #(.TO_CYCLES(TO)) dut (
        .clk(clk), .rstN(rstN), .start(start), .encode_done(encode_done),
        .lane_empty(lane_empty), .lane_seg_done(lane_seg_done),
        .lane_rd(lane_rd), .lane_code(lane_code), .lane_len(lane_len),
        .pk_valid(pk_valid), .pk_code(pk_code), .pk_len(pk_len),
        .pk_ready(pk_ready), .pk_flush(pk_flush), .pk_flush_ack(pk_flush_ack),
        .busy(busy), .done(done), .cur_lane(cur_lane), .bit_cnt(bit_cnt),
        .err_timeout(err_timeout)
    );

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic clear_tb();
        for (int l = 0; l < 4; l++) begin
            pend[l].delete();
            pend_n[l].delete();
            towr[l].delete();
            fifo[l].delete();
            freeze[l] = 0;
            cd[l] = 0;
        end
        exp_q.delete();
        exp_bits = '0;
    endtask

    task automatic seg1(input int l, input int n, input int len);
        cw_t c;
        pend_n[l].push_back(n);
        for (int k = 0; k < n; k++) begin
            c.code = 16'($urandom);
            c.len = 5'(len);
            pend[l].push_back(c);
        end
    endtask

    task automatic gen_random(input int rounds);
        cw_t c;
        int n;
        for (int r = 0; r < rounds; r++) begin
            for (int l = 0; l < 4; l++) begin
                n = $urandom_range(0, 4);
                pend_n[l].push_back(n);
                for (int k = 0; k < n; k++) begin
                    c.code = 16'($urandom);
                    case ($urandom_range(0, 7))
                        0: c.len = 5'd0;
                        1: c.len = 5'($urandom_range(17, 31));
                        default: c.len = 5'($urandom_range(1, 16));
                    endcase
                    pend[l].push_back(c);
                end
            end
        end
    endtask

    // Expected stream: rounds in order, lanes 0..3, zero-length codes
    // dropped, lengths capped at 16.
    task automatic model();
        int off[4];
        cw_t c;
        exp_q.delete();
        exp_bits = '0;
        for (int l = 0; l < 4; l++) off[l] = 0;
        for (int r = 0; r < pend_n[0].size(); r++) begin
            for (int l = 0; l < 4; l++) begin
                for (int k = 0; k < pend_n[l][r]; k++) begin
                    c = pend[l][off[l] + k];
                    if (c.len != 0) begin
                        if (c.len > 16) c.len = 5'd16;
                        exp_q.push_back(c);
                        exp_bits = exp_bits + 32'(c.len);
                    end
                end
                off[l] += pend_n[l][r];
            end
        end
    endtask

    task automatic load_seg(input int l);
        int n;
        if (pend_n[l].size() > 0) begin
            n = pend_n[l].pop_front();
            for (int k = 0; k < n; k++) towr[l].push_back(pend[l].pop_front());
        end
    endtask

    // Lane/packer environment: acts 1 time unit after each rising edge.
    initial begin : drv
        cw_t c;
        logic [1:0] prev_cur;
        logic busy_prev;
        bit ack_arm;
        int ack_cd;
        int lowcnt;
        bit all_idle;
        prev_cur = 0;
        busy_prev = 0;
        ack_arm = 0;
        ack_cd = 0;
        lowcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            lane_code = {$urandom, $urandom};
            lane_len = 20'($urandom);
            if (rd_req >= 0 && fifo[rd_req].size() > 0) begin
                c = fifo[rd_req].pop_front();
                lane_code[16*rd_req +: 16] = c.code;
                lane_len[5*rd_req +: 5] = c.len;
            end
            if (busy_prev && cur_lane != prev_cur) load_seg(int'(prev_cur));
            prev_cur = cur_lane;
            busy_prev = busy;
            for (int l = 0; l < 4; l++) begin
                if (!freeze[l] && towr[l].size() > 0) begin
                    if (cd[l] == 0) begin
                        fifo[l].push_back(towr[l].pop_front());
                        cd[l] = $urandom_range(0, 2);
                    end else begin
                        cd[l]--;
                    end
                end
            end
            all_idle = 1;
            for (int l = 0; l < 4; l++) begin
                lane_empty[l] = (fifo[l].size() == 0);
                lane_seg_done[l] = (towr[l].size() == 0);
                if (pend_n[l].size() != 0 || towr[l].size() != 0) all_idle = 0;
            end
            encode_done = all_idle;
            case (rdy_mode)
                0: pk_ready = 1'b1;
                1: pk_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (pk_valid) lowcnt++;
                    else lowcnt = 0;
                    pk_ready = (lowcnt > 10);
                end
            endcase
            pk_flush_ack = 1'b0;
            if (!rstN) ack_arm = 0;
            if (pk_flush) begin
                ack_arm = 1;
                ack_cd = $urandom_range(0, 3);
            end
            if (ack_arm) begin
                if (ack_cd == 0) begin
                    pk_flush_ack = 1'b1;
                    ack_arm = 0;
                end else begin
                    ack_cd--;
                end
            end
        end
    end

    // Monitor: samples 1 time unit before each rising edge.
    initial begin : mon
        cw_t e;
        logic [15:0] pc;
        logic [4:0] pl;
        bit stall;
        int l;
        stall = 0;
        forever begin
            @(negedge clk);
            #4;
            rd_req = -1;
            if (!rstN) begin
                stall = 0;
                continue;
            end
            if (stall)
                chk(pk_valid && pk_code == pc && pk_len == pl, "hold_stable",
                    {11'd0, pk_valid, pk_len, pk_code}, {11'd0, 1'b1, pl, pc});
            stall = pk_valid && !pk_ready;
            pc = pk_code;
            pl = pk_len;
            if (lane_rd != 4'd0) begin
                l = 0;
                for (int i = 0; i < 4; i++) if (lane_rd[i]) l = i;
                chk($onehot(lane_rd) && l == int'(cur_lane) && !lane_empty[l] && !pk_valid,
                    "lane_rd_legal", {28'd0, lane_rd}, 32'd1 << cur_lane);
                rd_req = l;
                if (want_first) begin
                    chk(lane_rd == 4'b0001, "first_rd_lane0", {28'd0, lane_rd}, 32'd1);
                    want_first = 0;
                end
            end
            if (pk_valid && pk_ready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_code", {11'd0, pk_len, pk_code}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(pk_code == e.code && pk_len == e.len, "code",
                        {11'd0, pk_len, pk_code}, {11'd0, e.len, e.code});
                end
            end
            if (pk_flush) flush_seen++;
        end
    end

    task automatic run_start();
        flush_seen = 0;
        model();
        for (int l = 0; l < 4; l++) load_seg(l);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk(busy && bit_cnt == 0 && cur_lane == 0, "start_state",
            {busy, bit_cnt[28:0], cur_lane}, 32'h8000_0000);
    endtask

    task automatic run_finish(input bit xs, input bit exp_err);
        int cyc;
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = xs && cyc == 15 && busy && exp_q.size() > 1;
        end
        start = 1'b0;
        chk(done, "run_done", {31'd0, done}, 32'd1);
        chk(bit_cnt == exp_bits, "bit_cnt", bit_cnt, exp_bits);
        chk(exp_q.size() == 0, "all_codes_issued", exp_q.size(), 32'd0);
        chk(flush_seen == 1, "flush_pulses", flush_seen, 32'd1);
        chk(err_timeout == exp_err, "err_timeout", {31'd0, err_timeout}, {31'd0, exp_err});
        chk(!busy, "not_busy_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk(done && bit_cnt == exp_bits, "done_hold", bit_cnt, exp_bits);
    endtask

    initial begin : main
        int cyc;
        int c2;
        rstN = 1'b0;
        clear_tb();
        repeat (3) @(negedge clk);
        chk(!busy && !done && !pk_valid && !pk_flush, "reset_ctrl",
            {28'd0, busy, done, pk_valid, pk_flush}, 32'd0);
        chk(bit_cnt == 0 && cur_lane == 0 && lane_rd == 0, "reset_regs", bit_cnt, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // one len-5 code per lane
        clear_tb();
        for (int l = 0; l < 4; l++) seg1(l, 1, 5);
        rdy_mode = 0;
        run_start();
        run_finish(0, 0);
        chk(bit_cnt == 32'd20, "bit_cnt_20", bit_cnt, 32'd20);

        // packer back-pressure, 10 cycles per code
        clear_tb();
        seg1(0, 2, 9); seg1(1, 0, 0); seg1(2, 1, 16); seg1(3, 1, 3);
        rdy_mode = 2;
        run_start();
        run_finish(0, 0);

        // zero-length drop and length saturation
        clear_tb();
        seg1(0, 1, 7); seg1(1, 1, 0); seg1(2, 1, 20); seg1(3, 0, 0);
        rdy_mode = 0;
        run_start();
        run_finish(0, 0);
        chk(bit_cnt == 32'd23, "bit_cnt_23", bit_cnt, 32'd23);

        for (int i = 0; i < 6; i++) begin
            clear_tb();
            gen_random($urandom_range(1, 3));
            rdy_mode = i % 3;
            run_start();
            run_finish(i == 1, 0);
        end

        // reset while a code is held
        clear_tb();
        for (int l = 0; l < 4; l++) seg1(l, 2, 4);
        rdy_mode = 2;
        run_start();
        cyc = 0;
        while (!(pk_valid && bit_cnt != 0) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk(pk_valid && bit_cnt != 0, "reach_hold", bit_cnt, 32'd4);
        rstN = 1'b0;
        #1;
        chk(!pk_valid && pk_code == 0 && pk_len == 0, "rst_pk",
            {11'd0, pk_valid, pk_len, pk_code}, 32'd0);
        chk(bit_cnt == 0 && cur_lane == 0 && lane_rd == 0, "rst_cnt", bit_cnt, 32'd0);
        chk(!busy && !done && !pk_flush && !err_timeout, "rst_flags",
            {28'd0, busy, done, pk_flush, err_timeout}, 32'd0);
        clear_tb();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        clear_tb();
        for (int l = 0; l < 4; l++) seg1(l, 1, 5);
        rdy_mode = 0;
        want_first = 1;
        run_start();
        run_finish(0, 0);
        chk(!want_first, "first_rd_seen", {31'd0, want_first}, 32'd0);

`ifdef VLC_SCHED_TIMEOUT_EN
        clear_tb();
        seg1(0, 0, 0); seg1(1, 0, 0); seg1(2, 2, 6); seg1(3, 1, 5);
        freeze[2] = 1;
        rdy_mode = 0;
        run_start();
        cyc = 0;
        c2 = 0;
        while (cur_lane != 2'd3 && cyc < 200) begin
            if (cur_lane == 2'd2) c2++;
            @(negedge clk);
            cyc++;
        end
        chk(cur_lane == 2'd3 && err_timeout, "timeout_skip",
            {30'd0, cur_lane}, 32'd3);
        chk(c2 == TO + 1, "timeout_cycles", c2, TO + 1);
        towr[2].delete();
        freeze[2] = 0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        exp_bits = exp_bits - 32'd12;
        run_finish(0, 1);
        clear_tb();
        for (int l = 0; l < 4; l++) seg1(l, 0, 0);
        run_start();
        chk(!err_timeout, "timeout_cleared", {31'd0, err_timeout}, 32'd0);
        run_finish(0, 0);
`else
        clear_tb();
        seg1(0, 1, 3); seg1(1, 0, 0); seg1(2, 2, 6); seg1(3, 1, 5);
        freeze[2] = 1;
        rdy_mode = 1;
        run_start();
        repeat (40) @(negedge clk);
        chk(cur_lane == 2'd2 && !err_timeout, "stall_waits",
            {30'd0, cur_lane}, 32'd2);
        freeze[2] = 0;
        run_finish(0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
